// File: rtl/pbit_update.sv
// ---------------------------------------------------------------------------
// pbit_update
//   Stochastic p-bit update cell. Each update_en request samples the signed
//   input current and a signed 8-bit random value from a 16-bit Galois LFSR.
//   Two cycles later it writes p_out = (clamp(8*I) + r >= 0) and pulses
//   p_valid. The datapath is fully pipelined, so back-to-back requests are
//   accepted. flip_count is a saturating count of p_out value changes.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   I_in        signed input current, WEIGHT_PRECISION bits
//   update_en   request one stochastic update using the current I_in
//   seed_load   load seed_in into the LFSR (0 maps to 16'hACE1)
//   seed_in     new LFSR seed
//   p_out       registered p-bit (1 = +1, 0 = -1)
//   p_valid     one-cycle pulse after each p_out write
//   flip_count  saturating count of p_out changes
// ---------------------------------------------------------------------------
module pbit_update #(
   parameter int          WEIGHT_PRECISION = 6,
   parameter logic [15:0] SEED             = 16'hACE1
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic signed [WEIGHT_PRECISION-1:0] I_in,
   input  logic                               update_en,
   input  logic                               seed_load,
   input  logic [15:0]                        seed_in,
   output logic                               p_out,
   output logic                               p_valid,
   output logic [7:0]                         flip_count
);

   // Working width: wide enough for 8*I without overflow and at least 10 bits
   // so that t + r (range -256..255) never wraps.
   localparam int SW = (WEIGHT_PRECISION + 4 > 10) ? WEIGHT_PRECISION + 4 : 10;

   logic [15:0]                        lfsr;
   logic [15:0]                        lfsr_step;
   logic signed [WEIGHT_PRECISION-1:0] i_reg;
   logic [7:0]                         r_reg;
   logic                               s1_valid;

   logic signed [SW-1:0] scaled;
   logic signed [SW-1:0] t_clamp;
   logic signed [SW-1:0] r_ext;
   logic signed [SW-1:0] sum;
   logic                 p_next;

   assign lfsr_step = (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr <= SEED;
      end else if (seed_load) begin
         lfsr <= (seed_in == 16'h0000) ? 16'hACE1 : seed_in;
      end else if (update_en) begin
         lfsr <= lfsr_step;
      end
   end

   // Stage 1: capture the operands. r comes from the LFSR value before this
   // edge, so a simultaneous seed_load does not affect the current request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         i_reg    <= '0;
         r_reg    <= '0;
         s1_valid <= 1'b0;
      end else begin
         s1_valid <= update_en;
         if (update_en) begin
            i_reg <= I_in;
            r_reg <= lfsr[7:0];
         end
      end
   end

   always_comb begin
      scaled  = $signed({{(SW-WEIGHT_PRECISION){i_reg[WEIGHT_PRECISION-1]}}, i_reg}) <<< 3;
      t_clamp = scaled;
      if (scaled > $signed(SW'(128))) begin
         t_clamp = $signed(SW'(128));
      end else if (scaled < -$signed(SW'(128))) begin
         t_clamp = -$signed(SW'(128));
      end
      r_ext  = $signed({{(SW-8){r_reg[7]}}, r_reg});
      sum    = t_clamp + r_ext;
      p_next = ~sum[SW-1];
   end

   // Stage 2: write p_out, raise p_valid for the following cycle, count flips.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_out      <= 1'b0;
         p_valid    <= 1'b0;
         flip_count <= 8'd0;
      end else begin
         p_valid <= s1_valid;
         if (s1_valid) begin
            p_out <= p_next;
            if ((p_next != p_out) && (flip_count != 8'hFF)) begin
               flip_count <= flip_count + 8'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_pbit_update.sv
// ---------------------------------------------------------------------------
// tb_pbit_update
//   Scoreboard bench for pbit_update. Each request pushes the expected p_out,
//   flip_count and the cycle on which p_valid must appear. A negedge monitor
//   pops and compares, and flags unexpected, late or missing pulses.
// ---------------------------------------------------------------------------
module tb_pbit_update;

   localparam int W = 6;

   logic               clk;
   logic               rst_n;
   logic signed [W-1:0] I_in;
   logic               update_en;
   logic               seed_load;
   logic [15:0]        seed_in;
   logic               p_out;
   logic               p_valid;
   logic [7:0]         flip_count;

   pbit_update #(.WEIGHT_PRECISION(W), .SEED(16'hACE1)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .I_in       (I_in),
      .update_en  (update_en),
      .seed_load  (seed_load),
      .seed_in    (seed_in),
      .p_out      (p_out),
      .p_valid    (p_valid),
      .flip_count (flip_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int       due;
      logic     p;
      logic [7:0] fc;
   } exp_t;

   exp_t       q[$];
   int         n_vec = 0;
   int         n_err = 0;
   int         cyc   = 0;
   int         pv_count = 0;

   logic [15:0] m_lfsr;
   logic        m_p;
   logic [7:0]  m_fc;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every p_valid must match the head of the queue on its due cycle.
   always @(negedge clk) begin
      if (rst_n) begin
         if (p_valid) begin
            pv_count++;
            n_vec++;
            if (q.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_p_valid cyc=%0d p_out=%0b required no pulse", cyc, p_out);
            end else if (q[0].due != cyc) begin
               n_err++;
               $display("FAIL p_valid_timing cyc=%0d actual pulse, required cyc=%0d", cyc, q[0].due);
               if (q[0].due < cyc) void'(q.pop_front());
            end else begin
               if (p_out !== q[0].p || flip_count !== q[0].fc) begin
                  n_err++;
                  $display("FAIL p_write cyc=%0d p_out=%0b flip_count=%0d required p_out=%0b flip_count=%0d",
                           cyc, p_out, flip_count, q[0].p, q[0].fc);
               end
               void'(q.pop_front());
            end
         end else if (q.size() > 0 && q[0].due <= cyc) begin
            n_vec++;
            n_err++;
            $display("FAIL missing_p_valid cyc=%0d required pulse due cyc=%0d", cyc, q[0].due);
            void'(q.pop_front());
         end
      end
   end

   function automatic logic model_p(input int i, input logic [7:0] r);
      int t;
      int rs;
      t = i * 8;
      if (t > 128)  t = 128;
      if (t < -128) t = -128;
      rs = (r > 127) ? int'(r) - 256 : int'(r);
      return (t + rs) >= 0;
   endfunction

   function automatic logic [15:0] model_step(input logic [15:0] s);
      return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
   endfunction

   // One cycle of stimulus; expectations are pushed when a request is driven.
   task automatic step(input logic en, input int i, input logic sl, input logic [15:0] si);
      exp_t e;
      update_en = en;
      I_in      = W'(i);
      seed_load = sl;
      seed_in   = si;
      if (en) begin
         e.p   = model_p(i, m_lfsr[7:0]);
         if (e.p != m_p && m_fc != 8'hFF) m_fc = m_fc + 8'd1;
         m_p   = e.p;
         e.fc  = m_fc;
         e.due = cyc + 2;
         q.push_back(e);
      end
      if (sl)      m_lfsr = (si == 16'h0000) ? 16'hACE1 : si;
      else if (en) m_lfsr = model_step(m_lfsr);
      @(posedge clk);
      #1;
      update_en = 1'b0;
      seed_load = 1'b0;
   endtask

   task automatic drain(input string name);
      int k;
      k = 0;
      while (q.size() > 0 && k < 10) begin
         @(posedge clk);
         #1;
         k++;
      end
      @(posedge clk);
      #1;
      n_vec++;
      if (q.size() != 0) begin
         n_err++;
         $display("FAIL %s_drain pending=%0d required 0", name, q.size());
         q.delete();
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      q.delete();
      m_lfsr = 16'hACE1;
      m_p    = 1'b0;
      m_fc   = 8'd0;
      update_en = 1'b0;
      seed_load = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      n_vec++;
      if (p_out !== 1'b0 || p_valid !== 1'b0 || flip_count !== 8'd0) begin
         n_err++;
         $display("FAIL reset_state p_out=%0b p_valid=%0b flip_count=%0d required 0/0/0",
                  p_out, p_valid, flip_count);
      end
   endtask

   // Directly after reset release: r=0xE1 -> 0, then r=0x70 -> 1.
   task automatic test_basic();
      logic [1:0] seen;
      int start;
      start = pv_count;
      step(1'b1, 0, 1'b0, 16'h0);
      step(1'b1, 0, 1'b0, 16'h0);
      drain("basic");
      n_vec++;
      if (pv_count - start != 2 || flip_count !== 8'd1 || p_out !== 1'b1) begin
         n_err++;
         $display("FAIL basic_seq pulses=%0d flip_count=%0d p_out=%0b required 2/1/1",
                  pv_count - start, flip_count, p_out);
      end
      seen = 2'b00;
   endtask

   task automatic test_bias_pos();
      int start;
      start = pv_count;
      for (int k = 0; k < 100; k++) step(1'b1, 16, 1'b0, 16'h0);
      drain("bias_pos");
      n_vec++;
      if (pv_count - start != 100) begin
         n_err++;
         $display("FAIL bias_pos_pulses actual=%0d required 100", pv_count - start);
      end
   endtask

   task automatic test_bias_neg();
      logic [7:0] fc0;
      step(1'b0, 0, 1'b1, 16'h5A3C);
      step(1'b1, -32, 1'b0, 16'h0);
      drain("bias_neg_pre");
      fc0 = m_fc;
      for (int k = 0; k < 100; k++) step(1'b1, -32, 1'b0, 16'h0);
      drain("bias_neg");
      n_vec++;
      if (flip_count !== fc0 || p_out !== 1'b0) begin
         n_err++;
         $display("FAIL bias_neg_hold flip_count=%0d p_out=%0b required %0d/0", flip_count, p_out, fc0);
      end
   endtask

   // seed 0 -> ACE1; load with update_en uses old r; 12F0 gives r=-16.
   task automatic test_seed_load();
      step(1'b0, 0, 1'b1, 16'h0000);
      step(1'b1, 0, 1'b0, 16'h0);
      step(1'b1, 0, 1'b1, 16'h12F0);
      step(1'b1, 0, 1'b0, 16'h0);
      step(1'b1, 1, 1'b0, 16'h0);
      step(1'b1, 2, 1'b0, 16'h0);
      drain("seed_load");
   endtask

   // Gaps with I_in wiggling: no pulses in bubble slots, I_in ignored.
   task automatic test_bubbles();
      for (int k = 0; k < 20; k++) begin
         step(1'b1, $urandom_range(0, 63) - 32, 1'b0, 16'h0);
         step(1'b0, $urandom_range(0, 63) - 32, 1'b0, 16'h0);
         if (k % 3 == 0) step(1'b0, $urandom_range(0, 63) - 32, 1'b0, 16'h0);
      end
      drain("bubbles");
   endtask

   task automatic test_saturation();
      for (int k = 0; k < 300; k++) step(1'b1, (k % 2 == 0) ? 16 : -16, 1'b0, 16'h0);
      drain("saturation");
      n_vec++;
      if (flip_count !== 8'd255) begin
         n_err++;
         $display("FAIL saturation actual=%0d required 255", flip_count);
      end
   endtask

   task automatic test_reset_inflight();
      update_en = 1'b1;
      I_in      = W'(16);
      @(posedge clk);
      #1;
      update_en = 1'b0;
      do_reset();
      n_vec++;
      if (p_out !== 1'b0 || flip_count !== 8'd0) begin
         n_err++;
         $display("FAIL reset_inflight_state p_out=%0b flip_count=%0d required 0/0", p_out, flip_count);
      end
      repeat (5) step(1'b0, 16, 1'b0, 16'h0);
      test_basic();
   endtask

   initial begin
      rst_n = 1'b0;
      I_in = '0;
      update_en = 1'b0;
      seed_load = 1'b0;
      seed_in = 16'h0;
      test_reset();
      test_basic();
      test_bias_pos();
      test_bias_neg();
      test_seed_load();
      test_bubbles();
      test_saturation();
      test_reset_inflight();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout cyc=%0d required completion", cyc);
      $fatal(1);
   end

endmodule
